// File: rtl/busport.sv
// busport: busio register file and registered memory-bus cycle engine with ready timeout
module busport #(
   parameter int AW  = 20,
   parameter int DW  = 64,
   parameter int TMO = 127
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_we,
   input  logic [1:0]    cpu_sel,
   input  logic [DW-1:0] cpu_d,
   output logic [DW-1:0] cpu_q,
   input  logic [1:0]    arx,
   input  logic          ecx,
   input  logic          wrx,
   input  logic          astb,
   input  logic          rd,
   input  logic          wr,
   output logic [AW-1:0] mem_addr,
   output logic          mem_astb,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall,
   output logic          timeout,
   input  logic          tmo_clr
);
   typedef enum logic [1:0] {IDLE, RWAIT, WWAIT} state_t;
   localparam logic [6:0] TMOV = 7'(TMO);
   state_t               state_q, state_d;
   logic [3:0][DW-1:0]   rg_q, rg_d;
   logic [1:0]           tgt_q, tgt_d;
   logic [6:0]           cnt_q, cnt_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic                 astb_q, astb_d, rd_q, rd_d, wr_q, wr_d, tmo_q, tmo_d;
   // Decode arbiter commands in IDLE, track ready/timeout in the wait states
   always_comb begin
      state_d = state_q;
      rg_d    = rg_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      astb_d  = 1'b0;
      rd_d    = rd_q;
      wr_d    = wr_q;
      tmo_d   = tmo_q & ~tmo_clr;
      if (cpu_we) rg_d[cpu_sel] = cpu_d;
      if (state_q == IDLE) begin
         if (ecx) begin
            if (astb && !wrx) begin
               addr_d = rg_q[arx][AW-1:0];
               astb_d = 1'b1;
            end
            if (rd && wrx) begin
               tgt_d   = arx;
               rd_d    = 1'b1;
               cnt_d   = '0;
               state_d = RWAIT;
            end else if (wr && !wrx) begin
               wdata_d = rg_q[arx];
               wr_d    = 1'b1;
               cnt_d   = '0;
               state_d = WWAIT;
            end
         end
      end else if (mem_ready) begin
         if (state_q == RWAIT) rg_d[tgt_q] = mem_rdata;
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         state_d = IDLE;
      end else if (cnt_q == TMOV) begin
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         tmo_d   = 1'b1;
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q + 7'd1;
      end
   end
   // State and output registers; reset aborts any cycle in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rg_q    <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         astb_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rg_q    <= rg_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         astb_q  <= astb_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         tmo_q   <= tmo_d;
      end
   end
   assign cpu_q     = rg_q[3];
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_astb  = astb_q;
   assign mem_rd    = rd_q;
   assign mem_wr    = wr_q;
   assign timeout   = tmo_q;
   assign stall     = state_q != IDLE;
endmodule
